// File: rtl/pdm_decimator_if.sv
// Sample-side and level-side signals of the PDM decimator.
// master drives the PDM stream and controls; slave is the decimator itself.
interface pdm_decimator_if #(
  parameter int WIN_LOG2 = 5
);
  logic                en;
  logic                pdm_in;
  logic                sync;
  logic [WIN_LOG2-1:0] level;
  logic                level_valid;
  logic                clip;
  logic                busy;

  modport master (
    output en, pdm_in, sync,
    input  level, level_valid, clip, busy
  );

  modport slave (
    input  en, pdm_in, sync,
    output level, level_valid, clip, busy
  );
endinterface

// File: rtl/pdm_decimator.sv
// Counts PDM ones over 2^WIN_LOG2 accepted samples; level/clip/level_valid are registered
// on the final-sample edge. No backpressure: en=0 simply pauses the current window.
module pdm_decimator #(
  parameter int WIN_LOG2 = 5
) (
  input  logic              clk,
  input  logic              reset,
  pdm_decimator_if.slave    bus
);

  localparam int                  WIN  = 1 << WIN_LOG2;
  localparam logic [WIN_LOG2-1:0] LAST = '1;
  localparam logic [WIN_LOG2:0]   FULL = (WIN_LOG2+1)'(WIN);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t              state, state_n;
  logic [WIN_LOG2:0]   acc, acc_n, sum, first;
  logic [WIN_LOG2-1:0] wcnt, wcnt_n;
  logic [WIN_LOG2-1:0] level_q, level_n;
  logic                clip_q, clip_n;
  logic                vld_q, vld_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      acc     <= '0;
      wcnt    <= '0;
      level_q <= '0;
      clip_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      wcnt    <= wcnt_n;
      level_q <= level_n;
      clip_q  <= clip_n;
      vld_q   <= vld_n;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    wcnt_n  = wcnt;
    level_n = level_q;
    clip_n  = clip_q;
    vld_n   = 1'b0;
    first   = {{WIN_LOG2{1'b0}}, bus.pdm_in};
    sum     = acc + first;

    // sync wins over window completion: the partial window is dropped, outputs hold
    if (bus.sync) begin
      state_n = ACCUM;
      acc_n   = bus.en ? first : '0;
      wcnt_n  = bus.en ? WIN_LOG2'(1) : '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.en) begin
            state_n = ACCUM;
            acc_n   = first;
            wcnt_n  = WIN_LOG2'(1);
          end
        end
        ACCUM: begin
          if (bus.en) begin
            if (wcnt == LAST) begin
              // only the all-ones window overflows the level width
              level_n = (sum == FULL) ? LAST : sum[WIN_LOG2-1:0];
              clip_n  = (sum == FULL);
              vld_n   = 1'b1;
              acc_n   = '0;
              wcnt_n  = '0;
            end else begin
              acc_n  = sum;
              wcnt_n = wcnt + WIN_LOG2'(1);
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.level       = level_q;
  assign bus.clip        = clip_q;
  assign bus.level_valid = vld_q;
  assign bus.busy        = (state == ACCUM);

endmodule
